// File: rtl/intr_sequencer.sv
// Interrupt entry / RETI sequencer: owns PCS, IHA, IRA and IDN, squashes the
// in-flight instruction and steers the PC-select mux on every redirect.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_RUN    | normal execution, interrupts may be taken
// ST_ENTER  | one-cycle flush + redirect to IHA
// ST_RETURN | one-cycle flush + redirect to IRA
// ST_SETTLE | post-redirect blackout, irq ignored until counter expires
module intr_sequencer #(
  parameter int                 DBITS         = 32,
  parameter logic [DBITS-1:0]   IHA_RESET     = 32'h0,
  parameter int                 SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             irq,
  input  logic [3:0]       idn,
  input  logic             hold,
  input  logic [DBITS-1:0] resume_pc,
  input  logic             reti,
  input  logic             sr_wr_en,
  input  logic [3:0]       sr_idx,
  input  logic [DBITS-1:0] sr_wr_data,
  output logic [DBITS-1:0] sr_rd_data,
  output logic             ie,
  output logic             flush,
  output logic             redirect_en,
  output logic [DBITS-1:0] redirect_pc
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_ENTER  = 2'd1,
    ST_RETURN = 2'd2,
    ST_SETTLE = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  localparam logic [3:0] IDX_PCS = 4'd0;
  localparam logic [3:0] IDX_IHA = 4'd1;
  localparam logic [3:0] IDX_IRA = 4'd2;
  localparam logic [3:0] IDX_IDN = 4'd3;

  state_t           state_q, state_d;
  logic [3:0]       settle_q, settle_d;
  logic             ie_q, ie_d;
  logic             oie_q, oie_d;
  logic [DBITS-1:0] iha_q, iha_d;
  logic [DBITS-1:0] ira_q, ira_d;
  logic [3:0]       idn_q, idn_d;
  logic             flush_q, flush_d;
  logic [DBITS-1:0] redirect_pc_q, redirect_pc_d;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    ie_d     = ie_q;
    oie_d    = oie_q;
    iha_d    = iha_q;
    ira_d    = ira_q;
    idn_d    = idn_q;

    // WSR first so that entry/reti below override it where they must win.
    if (sr_wr_en) begin
      case (sr_idx)
        IDX_PCS: {oie_d, ie_d} = sr_wr_data[1:0];
        IDX_IHA: iha_d = sr_wr_data;
        IDX_IRA: ira_d = sr_wr_data;
        default: ;
      endcase
    end

    case (state_q)
      ST_RUN, ST_SETTLE: begin
        if (reti) begin
          ie_d    = oie_q;
          oie_d   = oie_q;
          state_d = ST_RETURN;
        end else if (state_q == ST_RUN && irq && ie_q && !hold && settle_q == 4'd0) begin
          ira_d   = resume_pc;
          idn_d   = idn;
          oie_d   = ie_q;
          ie_d    = 1'b0;
          state_d = ST_ENTER;
        end else if (state_q == ST_SETTLE) begin
          if (settle_q <= 4'd1) begin
            settle_d = 4'd0;
            state_d  = ST_RUN;
          end else begin
            settle_d = settle_q - 4'd1;
          end
        end
      end
      ST_ENTER, ST_RETURN: begin
        settle_d = SETTLE_LOAD;
        state_d  = ST_SETTLE;
      end
      default: state_d = ST_RUN;
    endcase

    flush_d       = (state_d == ST_ENTER) || (state_d == ST_RETURN);
    redirect_pc_d = '0;
    if (state_d == ST_ENTER)  redirect_pc_d = iha_d;
    if (state_d == ST_RETURN) redirect_pc_d = ira_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      settle_q      <= 4'd0;
      ie_q          <= 1'b0;
      oie_q         <= 1'b0;
      iha_q         <= IHA_RESET;
      ira_q         <= '0;
      idn_q         <= 4'd0;
      flush_q       <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      settle_q      <= settle_d;
      ie_q          <= ie_d;
      oie_q         <= oie_d;
      iha_q         <= iha_d;
      ira_q         <= ira_d;
      idn_q         <= idn_d;
      flush_q       <= flush_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  // RSR sees pre-edge register values only.
  always_comb begin
    sr_rd_data = '0;
    case (sr_idx)
      IDX_PCS: sr_rd_data[1:0] = {oie_q, ie_q};
      IDX_IHA: sr_rd_data      = iha_q;
      IDX_IRA: sr_rd_data      = ira_q;
      IDX_IDN: sr_rd_data[3:0] = idn_q;
      default: ;
    endcase
  end

  assign ie          = ie_q;
  assign flush       = flush_q;
  assign redirect_en = flush_q;
  assign redirect_pc = redirect_pc_q;

endmodule

// File: tb/tb_intr_sequencer.sv
// Directed + randomized bench for intr_sequencer against a cycle-level
// behavioural model of the special registers and redirect pulses.
module tb_intr_sequencer;
  localparam int          DBITS = 32;
  localparam logic [31:0] IHA_RST = 32'h0;
  localparam int          SC = 2;

  logic        clk = 1'b0;
  logic        rst, irq, hold, reti, sr_wr_en;
  logic [3:0]  idn, sr_idx;
  logic [31:0] resume_pc, sr_wr_data, sr_rd_data, redirect_pc;
  logic        ie, flush, redirect_en;

  intr_sequencer #(.DBITS(DBITS), .IHA_RESET(IHA_RST), .SETTLE_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .irq(irq), .idn(idn), .hold(hold),
    .resume_pc(resume_pc), .reti(reti), .sr_wr_en(sr_wr_en), .sr_idx(sr_idx),
    .sr_wr_data(sr_wr_data), .sr_rd_data(sr_rd_data), .ie(ie), .flush(flush),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: architectural registers, a pending one-cycle redirect pulse and
  // the number of blackout cycles left before irq is honoured again.
  logic        m_ie, m_oie;
  logic [31:0] m_iha, m_ira;
  logic [3:0]  m_idn;
  int          m_quiet;
  bit          m_redir;
  logic [31:0] m_redir_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [3:0] idx);
    case (idx)
      4'd0:    return {30'd0, m_oie, m_ie};
      4'd1:    return m_iha;
      4'd2:    return m_ira;
      4'd3:    return {28'd0, m_idn};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_edge(input logic i_rst, input logic i_irq, input logic [3:0] i_idn,
                            input logic i_hold, input logic [31:0] i_rpc, input logic i_reti,
                            input logic i_we, input logic [3:0] i_idx, input logic [31:0] i_wd);
    logic        n_ie, n_oie;
    logic [31:0] n_iha, n_ira;
    logic [3:0]  n_idn;
    if (i_rst) begin
      m_ie = 0; m_oie = 0; m_iha = IHA_RST; m_ira = 0; m_idn = 0;
      m_quiet = 0; m_redir = 0; m_redir_pc = 0;
      return;
    end
    n_ie = m_ie; n_oie = m_oie; n_iha = m_iha; n_ira = m_ira; n_idn = m_idn;
    if (i_we) begin
      if (i_idx == 4'd0) begin n_oie = i_wd[1]; n_ie = i_wd[0]; end
      if (i_idx == 4'd1) n_iha = i_wd;
      if (i_idx == 4'd2) n_ira = i_wd;
    end
    if (m_redir) begin
      m_redir = 0;
      m_quiet = SC;
    end else if (i_reti) begin
      n_ie = m_oie; n_oie = m_oie;
      m_redir = 1; m_redir_pc = n_ira; m_quiet = 0;
    end else if (m_quiet == 0 && i_irq && m_ie && !i_hold) begin
      n_ira = i_rpc; n_idn = i_idn; n_oie = m_ie; n_ie = 0;
      m_redir = 1; m_redir_pc = n_iha;
    end else if (m_quiet > 0) begin
      m_quiet--;
    end
    m_ie = n_ie; m_oie = n_oie; m_iha = n_iha; m_ira = n_ira; m_idn = n_idn;
  endtask

  task automatic step(input logic i_rst, input logic i_irq, input logic [3:0] i_idn,
                      input logic i_hold, input logic [31:0] i_rpc, input logic i_reti,
                      input logic i_we, input logic [3:0] i_idx, input logic [31:0] i_wd);
    rst = i_rst; irq = i_irq; idn = i_idn; hold = i_hold; resume_pc = i_rpc;
    reti = i_reti; sr_wr_en = i_we; sr_idx = i_idx; sr_wr_data = i_wd;
    #1;
    chk("rsr", sr_rd_data, m_read(i_idx));
    @(posedge clk); #1;
    model_edge(i_rst, i_irq, i_idn, i_hold, i_rpc, i_reti, i_we, i_idx, i_wd);
    chk("flush", {31'd0, flush}, {31'd0, m_redir});
    chk("redirect_en", {31'd0, redirect_en}, {31'd0, m_redir});
    chk("redirect_pc", redirect_pc, m_redir ? m_redir_pc : 32'd0);
    chk("ie", {31'd0, ie}, {31'd0, m_ie});
  endtask

  task automatic idle(input int n, input logic i_irq);
    for (int k = 0; k < n; k++) step(0, i_irq, 4'h0, 0, 32'h0, 0, 0, 4'd0, 32'h0);
  endtask

  task automatic rsr(input logic [3:0] idx, input logic [31:0] exp, input string tag);
    sr_idx = idx;
    #1;
    chk(tag, sr_rd_data, exp);
  endtask

  initial begin
    int  gap;
    bit  found;
    m_ie = 0; m_oie = 0; m_iha = IHA_RST; m_ira = 0; m_idn = 0;
    m_quiet = 0; m_redir = 0; m_redir_pc = 0;
    rst = 1; irq = 0; idn = 0; hold = 0; resume_pc = 0; reti = 0;
    sr_wr_en = 0; sr_idx = 0; sr_wr_data = 0;

    // Reset and basic WSR/RSR.
    step(1, 0, 4'h0, 0, 32'h0, 0, 0, 4'd0, 32'h0);
    rsr(4'd1, IHA_RST, "reset_iha");
    rsr(4'd0, 32'h0, "reset_pcs");
    step(0, 0, 4'h0, 0, 32'h0, 0, 1, 4'd1, 32'h200);
    step(0, 0, 4'h0, 0, 32'h0, 0, 1, 4'd0, 32'h1);
    rsr(4'd1, 32'h200, "rsr_iha");
    rsr(4'd7, 32'h0, "rsr_idx7");
    chk("ie_after_wsr", {31'd0, ie}, 32'd1);

    // Basic entry, irq held high afterwards must not re-enter.
    step(0, 1, 4'h2, 0, 32'h48, 0, 0, 4'd0, 32'h0);
    chk("entry_pc", redirect_pc, 32'h200);
    chk("entry_flush", {31'd0, flush}, 32'd1);
    rsr(4'd2, 32'h48, "entry_ira");
    rsr(4'd3, 32'h2, "entry_idn");
    rsr(4'd0, 32'h2, "entry_pcs");
    idle(5, 1);

    // RETI with irq still high; re-entry follows the blackout.
    step(0, 1, 4'h2, 0, 32'h48, 1, 0, 4'd0, 32'h0);
    chk("reti_pc", redirect_pc, 32'h48);
    chk("reti_ie", {31'd0, ie}, 32'd1);
    // Entry is sampled SC+1 cycles after the RETURN cycle; the pulse shows one later.
    found = 0; gap = 0;
    for (int n = 1; n <= 20 && !found; n++) begin
      step(0, 1, 4'h2, 0, 32'h48, 0, 0, 4'd0, 32'h0);
      if (redirect_en) begin found = 1; gap = n; end
    end
    chk("reentry_gap", gap, SC + 2);
    idle(3, 0);
    step(0, 0, 4'h0, 0, 32'h0, 1, 0, 4'd0, 32'h0);
    idle(4, 0);

    // Hold deferral.
    for (int k = 0; k < 5; k++) step(0, 1, 4'h5, 1, 32'h70, 0, 0, 4'd2, 32'h0);
    rsr(4'd2, 32'h48, "hold_ira");
    step(0, 1, 4'h5, 0, 32'h5C, 0, 0, 4'd2, 32'h0);
    rsr(4'd2, 32'h5C, "hold_release_ira");
    idle(1, 0);
    step(0, 0, 4'h0, 0, 32'h0, 1, 0, 4'd0, 32'h0);
    idle(4, 0);

    // Entry beats WSR PCS.
    step(0, 1, 4'h6, 0, 32'h60, 0, 1, 4'd0, 32'h0);
    rsr(4'd0, 32'h2, "conflict_pcs");
    idle(1, 0);
    step(0, 0, 4'h0, 0, 32'h0, 1, 0, 4'd0, 32'h0);
    idle(4, 0);

    // WSR IHA applies and ENTER uses it.
    step(0, 1, 4'h7, 0, 32'h80, 0, 1, 4'd1, 32'h300);
    chk("conflict_iha_pc", redirect_pc, 32'h300);
    idle(1, 0);
    step(0, 0, 4'h0, 0, 32'h0, 1, 0, 4'd0, 32'h0);
    idle(4, 0);

    // reti and irq together: RETURN wins, IRA untouched.
    step(0, 1, 4'h9, 0, 32'h99, 1, 0, 4'd2, 32'h0);
    chk("reti_irq_pc", redirect_pc, 32'h80);
    rsr(4'd2, 32'h80, "reti_irq_ira");
    idle(4, 0);

    // Reset during ENTER.
    step(0, 1, 4'h1, 0, 32'hA0, 0, 0, 4'd0, 32'h0);
    step(1, 1, 4'h1, 0, 32'hA0, 0, 0, 4'd0, 32'h0);
    chk("rst_mid_redir", {31'd0, redirect_en}, 32'd0);
    chk("rst_mid_flush", {31'd0, flush}, 32'd0);
    rsr(4'd0, 32'h0, "rst_mid_pcs");
    rsr(4'd1, IHA_RST, "rst_mid_iha");

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      logic        r_we;
      logic [3:0]  r_idx;
      r_we  = ($urandom_range(0, 5) == 0);
      r_idx = 4'($urandom_range(0, 7));
      if (r_we && $urandom_range(0, 1) == 1) r_idx = 4'd0;
      step(($urandom_range(0, 150) == 0), ($urandom_range(0, 2) != 0), 4'($urandom),
           ($urandom_range(0, 3) == 0), $urandom, ($urandom_range(0, 12) == 0),
           r_we, r_idx, (r_idx == 4'd0) ? 32'($urandom_range(0, 3)) : $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/intr_sequencer.md
Name: intr_sequencer

Overview:
- Sequences the single-issue pipeline on interrupt entry and on RETI.
- Samples IRQ/IDN from the I/O controller and owns the special registers PCS, IHA, IRA and IDN.
- Requests the squash of the in-flight instruction and drives a redirect PC into the PC-select mux.
- Services RSR/WSR accesses from the pipeline register stage.

Parameters:
- DBITS, 32, data/address width.
- IHA_RESET, 32'h0, reset value of the handler address register.
- SETTLE_CYCLES, 2, blackout cycles after any redirect before a new interrupt may be taken (range 1..15).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- irq  in  1  level interrupt request from the I/O controller.
- idn  in  4  device number accompanying irq.
- hold  in  1  pipeline cannot be preempted this cycle (bubble inserted or store in pipeline register).
- resume_pc  in  DBITS  address of the oldest non-committed instruction (return address).
- reti  in  1  RETI decoded in the pipeline register stage.
- sr_wr_en  in  1  WSR commit.
- sr_idx  in  4  special-register index for RSR/WSR.
- sr_wr_data  in  DBITS  WSR data.
- sr_rd_data  out  DBITS  RSR data (combinational from sr_idx).
- ie  out  1  PCS.IE, routed to the I/O controller.
- flush  out  1  squash the instruction in decode and the pipeline register.
- redirect_en  out  1  select redirect_pc as the next PC.
- redirect_pc  out  DBITS  target PC.

Behaviour:
- Special-register indices: 0 = PCS ([0] IE, [1] OIE, rest read as 0); 1 = IHA; 2 = IRA; 3 = IDN (zero-extended). Other indices read 0; writes to them are ignored.
- IDN is read-only; a WSR to index 3 is ignored.
- Reset (rst high at a clk edge):
  - PCS=0, IHA=IHA_RESET, IRA=0, IDN=0, state=RUN, settle counter=0.
  - Outputs flush=0, redirect_en=0, redirect_pc=0, ie=0.
  - Reset mid-ENTER/RETURN aborts the sequence; no redirect is issued.
- States: RUN, ENTER, RETURN, SETTLE.
- RUN, evaluated in this priority order:
  1. reti=1: IE<=OIE, then -> RETURN.
  2. irq & IE & ~hold & (settle counter==0): IRA<=resume_pc, IDN<=idn, OIE<=IE, IE<=0, then -> ENTER.
  3. Otherwise stay in RUN.
- ENTER (1 cycle): flush=1, redirect_en=1, redirect_pc=IHA; then -> SETTLE with counter=SETTLE_CYCLES.
- RETURN (1 cycle): flush=1, redirect_en=1, redirect_pc=IRA; then -> SETTLE with counter=SETTLE_CYCLES.
- SETTLE: counter decrements each cycle; at 1 -> RUN with counter 0. irq is ignored; reti and WSR still apply in SETTLE.
  - reti in SETTLE: IE<=OIE, then -> RETURN.
- Outputs flush/redirect_en/redirect_pc are registered-state decodes: asserted exactly one cycle, in the cycle after the triggering sample. Total latency from irq sample to redirect is 1 cycle.
- WSR:
  - Takes effect at the clk edge.
  - Same-cycle conflict with interrupt entry: entry updates to PCS/IRA win over a WSR to the same register. A WSR to IHA still applies, and ENTER uses the updated IHA.
  - Same-cycle conflict with reti: reti wins over a WSR to PCS.
- RSR returns the pre-edge value; no bypass of a same-cycle write.
- irq deasserted before sampling: no entry; nothing is latched.
- irq held high across RETI: re-entry only after SETTLE completes and IE=1.
- ie output = PCS[0] at all times.
- hold=1 defers entry indefinitely; nothing is captured while hold=1.

Test Plan:
- Reset value and WSR/RSR: rst 1 cycle, then WSR IHA=32'h200, WSR PCS=1 -> RSR 1 reads 32'h200; ie=1; sr_rd_data=0 for idx 7.
- Basic entry: IE=1, irq=1, idn=4'h2, resume_pc=32'h48, hold=0 -> next cycle flush=1, redirect_en=1, redirect_pc=32'h200; IRA=32'h48, IDN=2, PCS=32'h2 (OIE=1, IE=0); no second entry while irq stays high.
- RETI: after entry and SETTLE, reti=1 -> next cycle redirect_pc=32'h48, redirect_en=1; PCS[0]=1; with irq still high, re-entry occurs exactly SETTLE_CYCLES+1 cycles after the RETURN cycle.
- hold deferral: irq=1, IE=1, hold=1 for 5 cycles -> no flush, IRA unchanged; hold drops with resume_pc=32'h5C -> entry with IRA=32'h5C.
- Conflicts: in the same cycle as entry, WSR PCS=0 and WSR IHA=32'h300 (two benches) -> PCS=32'h2 after entry; redirect_pc=32'h300. reti and irq in the same cycle -> RETURN taken, IRA unchanged.
- Mid-sequence reset: rst asserted during ENTER -> next cycle redirect_en=0, flush=0, PCS=0, IHA=IHA_RESET.
